wb_stim_responder: RTL and testbench

Synthesizable Wishbone slave for the core testbench: it feeds queued instruction words to the core's bus master and captures the core's write cycles into a result FIFO. It generalises the fixed single-cycle, 128-bit, always-acknowledge driver to a parametrised bus width, ack latency, queue depth and empty-queue policy. It sits between the agent/driver (push side) and the core's Wishbone port, and the result monitor drains the capture FIFO.

---
 rtl/wb_stim_pkg.sv | 13 +
 rtl/wb_stim_responder_fifo.sv | 39 +++
 rtl/wb_stim_responder.sv | 107 ++++++++++
 tb/tb_wb_stim_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stim_pkg.sv
// wb_stim_pkg: shared state encoding, default filler word and lane mapping for wb_stim_responder.
package wb_stim_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_TERM = 2'd2;
  localparam logic [31:0] FILL_WORD_DEF = 32'hF0801003;
  function automatic logic [127:0] lane_map(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [31:0] fill);
    lane_map = {4{fill}};
    lane_map[lane*32 +: 32] = w;
  endfunction
endpackage

// File: rtl/wb_stim_responder_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers and an occupancy count.
module sync_fifo import wb_stim_pkg::*; #(
  parameter int W = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic do_push, do_pop;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a push at full is still accepted
  assign do_push = push_i && (!full_o || do_pop);
  assign wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = do_pop ? rptr_q + (AW+1)'(1) : rptr_q;
  assign count_o = wptr_q - rptr_q;
  assign data_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/wb_stim_responder.sv
// wb_stim_responder: Wishbone slave feeding queued instruction words to a master
// and capturing its write cycles into a result FIFO.
module wb_stim_responder import wb_stim_pkg::*; #(
  parameter int          DATA_W    = 128,
  parameter int          QDEPTH    = 16,
  parameter int          RDEPTH    = 8,
  parameter int          ACK_LAT   = 0,
  parameter logic [31:0] FILL_WORD = FILL_WORD_DEF,
  parameter int          STRICT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid,
  input  logic [31:0]               inst_data,
  output logic                      inst_ready,
  output logic [$clog2(QDEPTH):0]   q_level,
  input  logic [31:0]               wb_adr_i,
  input  logic [DATA_W/8-1:0]       wb_sel_i,
  input  logic                      wb_we_i,
  input  logic [DATA_W-1:0]         wb_dat_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic [DATA_W-1:0]         wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      res_valid,
  output logic [31:0]               res_adr,
  output logic [DATA_W-1:0]         res_data,
  output logic [DATA_W/8-1:0]       res_sel,
  input  logic                      res_ready
);
  localparam int SW = DATA_W/8;
  localparam int CW = 32 + DATA_W + SW;
  localparam logic [2:0] LAT_M1 = (ACK_LAT > 0) ? 3'(ACK_LAT - 1) : 3'd0;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d, lane_dat, fill_dat;
  logic req, fire, q_pop, q_empty, q_full, c_full, c_empty;
  logic [31:0] q_head;
  logic [CW-1:0] c_head;
  assign req = wb_cyc_i && wb_stb_i;
  // a write waits at the termination point until the capture FIFO has room
  assign fire = req && ((state_q == ST_IDLE && ACK_LAT == 0) || (state_q == ST_WAIT && cnt_q == 3'd0))
                && (!wb_we_i || !c_full);
  assign q_pop = fire && !wb_we_i && !q_empty;
  assign fill_dat = {(DATA_W/32){FILL_WORD}};
  if (DATA_W == 128) begin : g_lane
    assign lane_dat = lane_map(q_head, wb_adr_i[3:2], FILL_WORD);
  end else begin : g_word
    assign lane_dat = q_head;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = dat_q;
    if (fire) begin
      state_d = ST_TERM;
      err_d = !wb_we_i && q_empty && STRICT != 0;
      ack_d = !err_d;
      dat_d = wb_we_i ? dat_q : !q_empty ? lane_dat : err_d ? '0 : fill_dat;
    end else if (state_q == ST_IDLE && req) begin
      state_d = ST_WAIT;
      cnt_d = LAT_M1;
    end else if (state_q == ST_WAIT) begin
      state_d = req ? ST_WAIT : ST_IDLE;
      cnt_d = (req && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    end else if (state_q == ST_TERM) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  sync_fifo #(.W(32), .DEPTH(QDEPTH)) u_inst_q (
    .clk(clk), .rst(rst), .push_i(inst_valid), .data_i(inst_data), .pop_i(q_pop),
    .data_o(q_head), .full_o(q_full), .empty_o(q_empty), .count_o(q_level)
  );
  assign inst_ready = !q_full;
  logic [$clog2(RDEPTH):0] c_count;
  sync_fifo #(.W(CW), .DEPTH(RDEPTH)) u_cap_q (
    .clk(clk), .rst(rst), .push_i(fire && wb_we_i), .data_i({wb_adr_i, wb_dat_i, wb_sel_i}),
    .pop_i(res_ready), .data_o(c_head), .full_o(c_full), .empty_o(c_empty), .count_o(c_count)
  );
  assign res_valid = !c_empty;
  assign res_adr = res_valid ? c_head[CW-1 -: 32] : '0;
  assign res_data = res_valid ? c_head[SW +: DATA_W] : '0;
  assign res_sel = res_valid ? c_head[SW-1:0] : '0;
  logic unused_ok;
  assign unused_ok = ^c_count;
endmodule

// File: tb/tb_wb_stim_responder.sv
// tb_wb_stim_responder: directed checks of two responder configurations sharing one bus stimulus.
module tb_wb_stim_responder;
  localparam logic [31:0] F = 32'hF0801003;
  logic clk = 1'b0, rst = 1'b1;
  logic a_inst_valid = 1'b0, b_inst_valid = 1'b0, we = 1'b0, a_cyc = 1'b0, b_cyc = 1'b0, stb = 1'b0;
  logic res_ready = 1'b0;
  logic [31:0] inst_data = '0, adr = '0;
  logic [15:0] sel = '0;
  logic [127:0] wdat = '0;
  logic a_inst_ready, a_ack, a_err, a_res_valid, b_inst_ready, b_ack, b_err, b_res_valid;
  logic [2:0] a_q_level;
  logic [4:0] b_q_level;
  logic [127:0] a_dat, a_res_data, b_dat, b_res_data;
  logic [31:0] a_res_adr, b_res_adr;
  logic [15:0] a_res_sel, b_res_sel;
  int checks = 0, errors = 0;
  logic seen;
  logic [127:0] exp_v;

  always #5 clk = ~clk;

  wb_stim_responder #(.DATA_W(128), .QDEPTH(4), .RDEPTH(2), .ACK_LAT(0), .STRICT(0)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(a_inst_valid), .inst_data(inst_data), .inst_ready(a_inst_ready),
    .q_level(a_q_level), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat),
    .wb_cyc_i(a_cyc), .wb_stb_i(stb), .wb_dat_o(a_dat), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .res_valid(a_res_valid), .res_adr(a_res_adr), .res_data(a_res_data), .res_sel(a_res_sel),
    .res_ready(res_ready));

  wb_stim_responder #(.DATA_W(128), .QDEPTH(16), .RDEPTH(8), .ACK_LAT(3), .STRICT(1)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(b_inst_valid), .inst_data(inst_data), .inst_ready(b_inst_ready),
    .q_level(b_q_level), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat),
    .wb_cyc_i(b_cyc), .wb_stb_i(stb), .wb_dat_o(b_dat), .wb_ack_o(b_ack), .wb_err_o(b_err),
    .res_valid(b_res_valid), .res_adr(b_res_adr), .res_data(b_res_data), .res_sel(b_res_sel),
    .res_ready(res_ready));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    a_cyc = 1'b0;
    b_cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_ack", a_ack, 0);
    check("rst_err", b_err, 0);
    check("rst_dat", a_dat, 0);
    check("rst_qlevel", a_q_level, 0);
    check("rst_ready", a_inst_ready, 1);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_res_adr", a_res_adr, 0);
    rst = 1'b0;
    step();
    // single word read on lane 2
    inst_data = 32'hE3A01005; a_inst_valid = 1'b1;
    step();
    a_inst_valid = 1'b0;
    check("push_qlevel", a_q_level, 1);
    adr = 32'h8; a_cyc = 1'b1; stb = 1'b1;
    step();
    check("rd_ack", a_ack, 1);
    check("rd_dat", a_dat, 128'hF0801003_E3A01005_F0801003_F0801003);
    check("rd_qlevel", a_q_level, 0);
    idle_bus();
    step();
    check("ack_pulse", a_ack, 0);
    check("dat_hold", a_dat, 128'hF0801003_E3A01005_F0801003_F0801003);
    // empty queue, lenient
    a_cyc = 1'b1; stb = 1'b1; adr = 32'h0;
    step();
    check("empty_ack", a_ack, 1);
    check("empty_err", a_err, 0);
    check("empty_dat", a_dat, {4{F}});
    idle_bus();
    step();
    // overfill a 4-deep queue
    for (int i = 0; i < 5; i++) begin
      inst_data = 32'h1000 + 32'(i); a_inst_valid = 1'b1;
      step();
      if (i == 3) check("full_ready", a_inst_ready, 0);
    end
    a_inst_valid = 1'b0;
    check("full_qlevel", a_q_level, 4);
    for (int i = 0; i < 4; i++) begin
      adr = 32'(i * 4); a_cyc = 1'b1; stb = 1'b1;
      step();
      exp_v = {4{F}};
      exp_v[i*32 +: 32] = 32'h1000 + 32'(i);
      check("drain_ack", a_ack, 1);
      check("drain_dat", a_dat, exp_v);
      idle_bus();
      step();
    end
    check("drain_qlevel", a_q_level, 0);
    // capture FIFO backpressure, depth 2
    sel = 16'hFFFF;
    for (int k = 1; k <= 2; k++) begin
      adr = 32'h100 + 32'((k - 1) * 4); wdat = 128'(k); we = 1'b1; a_cyc = 1'b1; stb = 1'b1;
      step();
      check("wr_ack", a_ack, 1);
      idle_bus();
      step();
    end
    check("cap_valid", a_res_valid, 1);
    check("cap_head0", a_res_adr, 32'h100);
    adr = 32'h108; wdat = 128'd3; sel = 16'h00F0; we = 1'b1; a_cyc = 1'b1; stb = 1'b1;
    step();
    check("stall_ack0", a_ack, 0);
    step();
    check("stall_ack1", a_ack, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("free_ack", a_ack, 0);
    step();
    check("late_ack", a_ack, 1);
    idle_bus();
    check("cap_head1", a_res_adr, 32'h104);
    check("cap_data1", a_res_data, 128'd2);
    res_ready = 1'b1;
    step();
    check("cap_head2", a_res_adr, 32'h108);
    check("cap_data2", a_res_data, 128'd3);
    check("cap_sel2", a_res_sel, 16'h00F0);
    step();
    res_ready = 1'b0;
    check("cap_empty", a_res_valid, 0);
    sel = '0;
    // latency 3 on the second instance
    inst_data = 32'hE1A00000; b_inst_valid = 1'b1;
    step();
    b_inst_valid = 1'b0;
    check("b_qlevel", b_q_level, 1);
    adr = 32'h4; b_cyc = 1'b1; stb = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("lat_noack", b_ack, 0);
    end
    step();
    check("lat_ack", b_ack, 1);
    check("lat_dat", b_dat, {F, F, 32'hE1A00000, F});
    idle_bus();
    step();
    check("lat_qlevel", b_q_level, 0);
    // aborted access leaves the queue untouched
    inst_data = 32'h000000AB; b_inst_valid = 1'b1;
    step();
    b_inst_valid = 1'b0;
    adr = 32'h0; b_cyc = 1'b1; stb = 1'b1;
    step(2);
    idle_bus();
    seen = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      seen = seen | b_ack | b_err;
    end
    check("abort_noterm", seen, 0);
    check("abort_qlevel", b_q_level, 1);
    b_cyc = 1'b1; stb = 1'b1;
    step(4);
    check("abort_rd_ack", b_ack, 1);
    check("abort_rd_dat", b_dat, {F, F, F, 32'h000000AB});
    idle_bus();
    step();
    // strict empty read
    b_cyc = 1'b1; stb = 1'b1;
    step(4);
    check("strict_err", b_err, 1);
    check("strict_ack", b_ack, 0);
    check("strict_dat", b_dat, 0);
    idle_bus();
    step();
    check("strict_err_pulse", b_err, 0);
    // reset during WAIT
    for (int i = 0; i < 3; i++) begin
      inst_data = 32'h2000 + 32'(i); b_inst_valid = 1'b1;
      step();
    end
    b_inst_valid = 1'b0;
    check("pre_rst_qlevel", b_q_level, 3);
    b_cyc = 1'b1; stb = 1'b1;
    step(2);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_ack", b_ack, 0);
    check("rst_wait_qlevel", b_q_level, 0);
    check("rst_wait_res", b_res_valid, 0);
    check("rst_wait_ready", b_inst_ready, 1);
    idle_bus();
    step(2);
    rst = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      seen = seen | b_ack | b_err;
    end
    check("rst_no_ack", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
